// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the baud divider helper.
package uart_tx_io_pkg;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int unsigned calc_divider(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX byte queue with separate occupancy count; DEPTH must be a power
// of two and at least 2 so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave the count unchanged, even when full.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, wr_ptr aliases rd_ptr; the popped head is read before the edge
  // so a simultaneous push into the same slot is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter (DATA store at 0x0, STATUS load at 0x4).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise one holding register.
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_sel,
  input  logic [3:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wmask,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        txd
);

  localparam int unsigned DIVIDER = calc_divider(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = $clog2(DIVIDER);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIVIDER - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic             overrun;

  logic       wr_req;
  logic       rd_req;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       busy;
  logic       bit_end;
  logic       ovr_set;
  logic [31:0] status_word;

  logic unused_bits;
  assign unused_bits = ^{io_wdata[31:8], io_wmask[3:1], FIFO_DEPTH[0]};

  assign wr_req  = io_sel && (io_addr == UART_DATA_OFS) && io_wmask[0];
  assign rd_req  = io_sel && io_rstrb;
  assign bit_end = (baud_cnt == '0);
  assign pop     = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign push    = wr_req && (!full || pop);
  assign ovr_set = wr_req && full && !pop;
  assign busy    = (state != ST_IDLE) || !empty;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (io_wdata[7:0]),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );
`else
  logic [7:0] hold_q;
  logic       hold_vld;

  // Valid stays set when a push replaces the byte being popped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   hold_vld <= 1'b0;
    else if (push) hold_vld <= 1'b1;
    else if (pop)  hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold_q <= io_wdata[7:0];
  end

  assign head  = hold_q;
  assign full  = hold_vld;
  assign empty = !hold_vld;
`endif

  // Serialiser FSM: every bit lasts DIVIDER cycles, ending when baud_cnt hits 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            state    <= ST_START;
            txd      <= 1'b0;
            baud_cnt <= CNT_RELOAD;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            bit_idx  <= '0;
            txd      <= shifter[0];
            baud_cnt <= CNT_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= CNT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!empty) begin
              state    <= ST_START;
              txd      <= 1'b0;
              baud_cnt <= CNT_RELOAD;
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Shifter is pure data: loaded on pop, shifted as each data bit completes.
  always_ff @(posedge clk) begin
    if (pop)                               shifter <= head;
    else if ((state == ST_DATA) && bit_end) shifter <= {1'b0, shifter[7:1]};
  end

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = busy;
    status_word[STAT_FULL]    = full;
    status_word[STAT_OVERRUN] = overrun;
  end

  // A same-cycle overrun beats the clear from a STATUS read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun  <= 1'b0;
      io_rdata <= '0;
    end else begin
      if (ovr_set)
        overrun <= 1'b1;
      else if (rd_req && (io_addr == UART_STATUS_OFS))
        overrun <= 1'b0;

      if (rd_req)
        io_rdata <= (io_addr == UART_STATUS_OFS) ? status_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io at DIVIDER=4: a line monitor decodes frames
// and compares them against bytes queued by the stimulus.
module tb_uart_tx_io;

  localparam int DIV = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_sel = 1'b0;
  logic [3:0]  io_addr = 4'h0;
  logic [31:0] io_wdata = 32'd0;
  logic [3:0]  io_wmask = 4'h0;
  logic        io_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        txd;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int frames_seen = 0;
  logic [7:0] sb_q[$];
  int starts_q[$];

  uart_tx_io #(
    .CLK_FREQ_HZ (400),
    .BAUD        (100),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_sel   (io_sel),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wmask (io_wmask),
    .io_rstrb (io_rstrb),
    .io_rdata (io_rdata),
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge resetn) rst_cnt++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // All bus tasks are entered right after a falling clock edge.
  task automatic idle();
    io_sel = 1'b0;
    io_wmask = 4'h0;
    io_rstrb = 1'b0;
  endtask

  task automatic drive_wr(input logic sel, input logic [3:0] mask, input logic [7:0] d);
    io_sel = sel;
    io_addr = 4'h0;
    io_wmask = mask;
    io_rstrb = 1'b0;
    io_wdata = {24'hABCDEF, d};
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    io_sel = 1'b1;
    io_addr = a;
    io_wmask = 4'h0;
    io_rstrb = 1'b1;
    @(negedge clk);
    idle();
    v = io_rdata;
  endtask

  task automatic wait_cyc(input int n);
    idle();
    repeat (n) @(negedge clk);
  endtask

  // Line receiver: samples each bit mid-period, drops frames cut by a reset.
  initial begin : monitor
    logic [9:0] bits;
    int rc;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && txd === 1'b0) begin
        rc = rst_cnt;
        starts_q.push_back(cyc);
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? 2 : DIV) @(negedge clk);
          bits[b] = txd;
        end
        @(negedge clk);
        if (rc == rst_cnt && resetn === 1'b1) begin
          chk("mon_start_bit", {31'd0, bits[0]}, 32'd0);
          chk("mon_stop_bit", {31'd0, bits[9]}, 32'd1);
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected_frame: got byte 0x%0h expected no frame", bits[8:1]);
          end else begin
            exp_b = sb_q.pop_front();
            chk("mon_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
          end
          frames_seen++;
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] v;
    logic [7:0] b;
    logic exp_lvl;
    int bit_no;
    int frames0;
    int lows;
    int n;

    // Reset and idle state
    repeat (3) @(negedge clk);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_rdata", io_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    rd(4'h4, v);
    chk("t1_status", v, 32'd0);
    chk("t1_txd_idle", {31'd0, txd}, 32'd1);

    // Single frame, waveform checked against the 8N1 bit schedule
    sb_q.push_back(8'h55);
    drive_wr(1'b1, 4'h1, 8'h55);
    idle();
    chk("t2_txd_before_start", {31'd0, txd}, 32'd1);
    @(negedge clk);
    for (int j = 0; j < 10 * DIV; j++) begin
      if (j > 0) @(negedge clk);
      bit_no = j / DIV;
      if (bit_no == 0) exp_lvl = 1'b0;
      else if (bit_no == 9) exp_lvl = 1'b1;
      else begin
        b = 8'h55;
        exp_lvl = b[bit_no - 1];
      end
      chk($sformatf("t2_txd_cycle%0d", j), {31'd0, txd}, {31'd0, exp_lvl});
    end
    rd(4'h4, v);
    chk("t2_busy_last_stop_cycle", v, 32'd1);
    rd(4'h4, v);
    chk("t2_status_after_frame", v, 32'd0);

    // Back-to-back frames with no idle gap
    starts_q.delete();
    sb_q.push_back(8'hA3);
    sb_q.push_back(8'h0F);
    drive_wr(1'b1, 4'h1, 8'hA3);
    drive_wr(1'b1, 4'h1, 8'h0F);
    idle();
    rd(4'h4, v);
    chk("t3_status_queued", v, (CAP == 1) ? 32'd3 : 32'd1);
    wait_cyc(20 * DIV + 5);
    chk("t3_frame_count", starts_q.size(), 32'd2);
    if (starts_q.size() == 2)
      chk("t3_frame_spacing", starts_q[1] - starts_q[0], 10 * DIV);
    rd(4'h4, v);
    chk("t3_status_done", v, 32'd0);
    chk("t3_sb_drained", sb_q.size(), 32'd0);

    // Overrun: capacity+1 writes while the first frame is on the line
    sb_q.push_back(8'h11);
    drive_wr(1'b1, 4'h1, 8'h11);
    idle();
    @(negedge clk);
    for (int k = 0; k <= CAP; k++) begin
      if (k < CAP) sb_q.push_back(8'h20 + 8'(k));
      drive_wr(1'b1, 4'h1, 8'h20 + 8'(k));
    end
    idle();
    rd(4'h4, v);
    chk("t4_status_overrun", v, 32'd7);
    rd(4'h4, v);
    chk("t4_status_cleared", v, 32'd3);
    @(negedge clk);
    chk("t4_rdata_hold", io_rdata, 32'd3);
    rd(4'h0, v);
    chk("t4_read_data_ofs", v, 32'd0);
    wait_cyc((CAP + 1) * 10 * DIV + 20);
    rd(4'h4, v);
    chk("t4_status_done", v, 32'd0);
    chk("t4_sb_drained", sb_q.size(), 32'd0);

    // Asynchronous reset in the middle of data bit 3
    frames0 = frames_seen;
    drive_wr(1'b1, 4'h1, 8'hF0);
    idle();
    repeat (3 * DIV + DIV + 2) @(negedge clk);
    chk("t5_txd_in_bit3", {31'd0, txd}, 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_txd_async_reset", {31'd0, txd}, 32'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_cyc(15 * DIV);
    chk("t5_no_residual_frame", frames_seen, frames0);
    rd(4'h4, v);
    chk("t5_status_after_reset", v, 32'd0);

    // Ignored writes: wrong byte lane, block not selected
    drive_wr(1'b1, 4'b0010, 8'h5A);
    drive_wr(1'b0, 4'b0001, 8'h5A);
    idle();
    lows = 0;
    for (int j = 0; j < 5 * DIV; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("t6_txd_stays_idle", lows, 0);
    rd(4'h4, v);
    chk("t6_status", v, 32'd0);

    // Random single and back-to-back bytes
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        sb_q.push_back(b);
        drive_wr(1'b1, 4'h1 | 4'($urandom_range(0, 15)), b);
      end
      idle();
      wait_cyc(n * 10 * DIV + $urandom_range(3, 12));
      rd(4'h4, v);
      chk($sformatf("rand%0d_status", it), v, 32'd0);
    end

    chk("final_sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
